// File: rtl/ser_chain_pkg.sv
// Shared definitions for the bit-serial arithmetic chain.
//   ser_state_t : serializer FSM state encoding
//   cnt_w()     : bit-counter width for a given word width, never below 1
//   frame_t     : per-bit framing strobes (start/end of word)
package ser_chain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Width of a counter that indexes bits 0..width-1; at least one bit wide.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    typedef struct packed {
        logic sof;
        logic eof;
    } frame_t;

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word input handshake for the serializer.
//   s_data  : parallel word, bit 0 = LSB
//   s_valid : s_data valid
//   s_ready : sink can accept; transfer on s_valid & s_ready at rising edge
interface word_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/word_hold_reg.sv
// One-entry holding register for the next word while the shifter is busy.
//   clk, rstn : clock, async active-low reset
//   load      : capture din and mark full
//   take      : mark empty (contents moved to the shifter)
//   din       : word to capture
//   data, vld : held word and its full flag
module word_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    // load and take are mutually exclusive: load needs an empty slot, take a full one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            data <= din;
            vld  <= 1'b1;
        end else if (take) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in, LSB-first bit stream out,
// one bit per ser_en cycle, with sof/eof framing and a one-word holding slot
// so back-to-back words stream without a bubble.
//   clk, rstn  : clock, async active-low reset
//   s          : word input handshake (slave side)
//   ser_en     : downstream advance enable, 0 stalls the stream
//   ser_out    : current serial bit (shifter bit 0)
//   ser_valid  : ser_out consumed this cycle
//   ser_sof    : first bit (LSB) of a word, qualified by ser_valid
//   ser_eof    : last bit (MSB) of a word, qualified by ser_valid
//   busy       : a word is being shifted
module word_serializer
    import ser_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    word_serializer_if.slave   s,
    input  logic               ser_en,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               ser_sof,
    output logic               ser_eof,
    output logic               busy
);

    localparam int unsigned          CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_data;
    logic             hold_vld;
    logic             hold_load;
    logic             hold_take;
    logic             accept;
    frame_t           frame;

    // Ready depends only on registered state
    assign s.s_ready = ~hold_vld;
    assign accept    = s.s_valid & ~hold_vld;

    word_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk  (clk),
        .rstn (rstn),
        .load (hold_load),
        .take (hold_take),
        .din  (s.s_data),
        .data (hold_data),
        .vld  (hold_vld)
    );

    // State, shifter and bit counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, shifter update and holding-register control
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        hold_load = 1'b0;
        hold_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = s.s_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Any accept lands in the hold slot unless it bypasses straight
                // into the shifter on the last bit below.
                hold_load = accept;
                if (ser_en) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (hold_vld) begin
                            sh_d      = hold_data;
                            hold_take = 1'b1;
                        end else if (accept) begin
                            sh_d      = s.s_data;
                            hold_load = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = sh_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial outputs decoded from registered state and ser_en
    always_comb begin
        busy      = (state_q == SHIFT);
        ser_valid = busy & ser_en;
        frame.sof = ser_valid & (cnt_q == '0);
        frame.eof = ser_valid & (cnt_q == LAST);
        ser_out   = sh_q[0];
        ser_sof   = frame.sof;
        ser_eof   = frame.eof;
    end

endmodule
